// File: rtl/lsu_pkg.sv
// Package for the load/store unit.
// Holds the access-size and FSM state enums and the legality check for a request.
// The SZ_* enum members act as the size constants for the rest of the design.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_t;

    // An op is illegal if its size is reserved or its address is not
    // naturally aligned for that size.
    function automatic logic is_illegal(size_t size, logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle around the load/store unit.
// Groups three sides of the unit:
//   request   : req_valid/req_ready handshake plus op fields, and stall
//   memory    : MRE, MWE, addressData, storeData, mem_be, mem_ready, loadedData
//   writeback : wb_valid, wb_rd, wb_data, st_done, err
// Handshake: an op transfers on a rising edge where req_valid and req_ready
// are both high; the requester holds the op fields stable while req_valid is
// high and req_ready is low. mem_ready completes the access in progress on the
// edge where it is sampled high.
// Modports: slave = the LSU itself; master = the environment (execute stage
// plus memory) that drives requests and responds to accesses.
interface load_store_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 4
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;
    logic [REG_W-1:0]      req_rd;
    logic                  stall;

    logic                  MRE;
    logic                  MWE;
    logic [ADDR_W-1:0]     addressData;
    logic [DATA_W-1:0]     storeData;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ready;
    logic [DATA_W-1:0]     loadedData;

    logic                  wb_valid;
    logic [REG_W-1:0]      wb_rd;
    logic [31:0]           wb_data;
    logic                  st_done;
    logic                  err;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        output req_ready, stall,
        output MRE, MWE, addressData, storeData, mem_be,
        input  mem_ready, loadedData,
        output wb_valid, wb_rd, wb_data, st_done, err
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  req_ready, stall,
        input  MRE, MWE, addressData, storeData, mem_be,
        output mem_ready, loadedData,
        input  wb_valid, wb_rd, wb_data, st_done, err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
// Ports:
//   size, off, sgn   : access size, byte offset within the bus word, sign-extend flag
//   wdata            : 32-bit store data (low bits used for byte/half)
//   rdata            : bus-wide read data from memory
//   be               : byte enables for the selected lanes
//   sdata            : store data replicated across all lanes of its size
//   ldata            : load data extracted from byte 'off', extended to 32 bits
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  size_t              size,
    input  logic [OFF_W-1:0]   off,
    input  logic               sgn,
    input  logic [31:0]        wdata,
    input  logic [DATA_W-1:0]  rdata,
    output logic [BE_W-1:0]    be,
    output logic [DATA_W-1:0]  sdata,
    output logic [31:0]        ldata
);

    logic [BE_W-1:0] be_base;
    logic [31:0]     lane;

    // Bring the addressed byte down to bit 0; the cast keeps only the low word.
    assign lane = 32'(rdata >> {off, 3'b000});

    always_comb begin
        be_base = '0;
        sdata   = '0;
        ldata   = '0;
        case (size)
            SZ_BYTE: begin
                be_base = BE_W'(1);
                sdata   = {(DATA_W / 8){wdata[7:0]}};
                ldata   = {{24{sgn & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                be_base = BE_W'(3);
                sdata   = {(DATA_W / 16){wdata[15:0]}};
                ldata   = {{16{sgn & lane[15]}}, lane[15:0]};
            end
            SZ_WORD: begin
                be_base = BE_W'(4'hF);
                sdata   = {(DATA_W / 32){wdata}};
                ldata   = lane;
            end
            default: begin
                be_base = '0;
                sdata   = '0;
                ldata   = '0;
            end
        endcase
    end

    assign be = be_base << off;

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the execute stage and data memory.
// Accepts one op at a time, drives a held memory access with byte enables,
// waits for mem_ready (with a timeout), then spends one RESP cycle pulsing
// exactly one of wb_valid (load), st_done (store) or err. A new op may be
// accepted during RESP so accesses can run back-to-back.
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   bus        : request / memory / writeback bundle (slave side)
//   dbg_state  : current FSM state, for observation only
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus,
    output lsu_state_t       dbg_state
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT);

    lsu_state_t state_q, state_d;

    // Latched op fields still needed once the access is in flight.
    logic              lat_store;
    logic              lat_signed;
    size_t             lat_size;
    logic [OFF_W-1:0]  lat_off;
    logic [REG_W-1:0]  lat_rd;
    logic [CNT_W-1:0]  cnt_q;

    // Registered outputs.
    logic              mre_q, mwe_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [BE_W-1:0]   be_q;
    logic              wb_valid_q, st_done_q, err_q;
    logic [REG_W-1:0]  wb_rd_q;
    logic [31:0]       wb_data_q;

    logic              ready;
    logic              accept;
    logic              illegal;
    logic              timeout_hit;

    size_t             al_size;
    logic [OFF_W-1:0]  al_off;
    logic              al_sgn;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_sdata;
    logic [31:0]       al_ldata;

    assign ready       = (state_q == IDLE) || (state_q == RESP);
    assign accept      = bus.req_valid & ready;
    assign illegal     = is_illegal(size_t'(bus.req_size), bus.req_addr[1:0]);
    assign timeout_hit = (state_q == ACCESS) && !bus.mem_ready
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    // One aligner serves both phases: while accepting it sees the incoming
    // request (for be/storeData), during ACCESS it sees the latched op (for
    // extracting load data).
    assign al_size = ready ? size_t'(bus.req_size) : lat_size;
    assign al_off  = ready ? bus.req_addr[OFF_W-1:0] : lat_off;
    assign al_sgn  = ready ? bus.req_signed : lat_signed;

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size  (al_size),
        .off   (al_off),
        .sgn   (al_sgn),
        .wdata (bus.req_wdata),
        .rdata (bus.loadedData),
        .be    (al_be),
        .sdata (al_sdata),
        .ldata (al_ldata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = illegal ? RESP : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // mem_ready takes priority over an expiring timeout.
                if (bus.mem_ready || timeout_hit) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath, latched op and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_store  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_off    <= '0;
            lat_rd     <= '0;
            cnt_q      <= '0;
            mre_q      <= 1'b0;
            mwe_q      <= 1'b0;
            addr_q     <= '0;
            sdata_q    <= '0;
            be_q       <= '0;
            wb_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    mre_q <= 1'b0;
                    mwe_q <= 1'b0;
                    if (accept) begin
                        lat_store  <= bus.req_store;
                        lat_signed <= bus.req_signed;
                        lat_size   <= size_t'(bus.req_size);
                        lat_off    <= bus.req_addr[OFF_W-1:0];
                        lat_rd     <= bus.req_rd;
                        cnt_q      <= '0;
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            mre_q   <= ~bus.req_store;
                            mwe_q   <= bus.req_store;
                            addr_q  <= bus.req_addr & ~ADDR_W'(BE_W - 1);
                            sdata_q <= al_sdata;
                            be_q    <= al_be;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        mre_q <= 1'b0;
                        mwe_q <= 1'b0;
                        if (lat_store) begin
                            st_done_q <= 1'b1;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= lat_rd;
                            wb_data_q  <= al_ldata;
                        end
                    end else if (timeout_hit) begin
                        mre_q <= 1'b0;
                        mwe_q <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    mre_q <= 1'b0;
                    mwe_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.stall       = bus.req_valid & ~ready;
    assign bus.MRE         = mre_q;
    assign bus.MWE         = mwe_q;
    assign bus.addressData = addr_q;
    assign bus.storeData   = sdata_q;
    assign bus.mem_be      = be_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.st_done     = st_done_q;
    assign bus.err         = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit (DATA_W=32, ADDR_W=32, REG_W=4, TIMEOUT=16).
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit          store;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  rd;
        int          waits;
    } op_t;

    logic       clk;
    logic       rst;
    lsu_state_t dbg_state;
    int         n_vec;
    int         n_err;

    load_store_unit_if #(.DATA_W(32), .ADDR_W(32), .REG_W(4)) bus ();

    load_store_unit #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .REG_W   (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expectations from the access rules with plain arithmetic.
    function automatic bit model_illegal(op_t o);
        return (o.size == 2'd3) || (o.size == 2'd1 && (o.addr % 2) != 0)
               || (o.size == 2'd2 && (o.addr % 4) != 0);
    endfunction

    function automatic logic [3:0] model_be(op_t o);
        int off = int'(o.addr % 4);
        case (o.size)
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] model_sdata(op_t o);
        case (o.size)
            2'd0:    return {24'h0, o.wdata[7:0]} * 32'h0101_0101;
            2'd1:    return {16'h0, o.wdata[15:0]} * 32'h0001_0001;
            default: return o.wdata;
        endcase
    endfunction

    function automatic logic [31:0] model_load(op_t o);
        longint off = longint'(o.addr % 4);
        longint d   = longint'(o.rdata);
        longint v;
        case (o.size)
            2'd0: begin
                v = (d >> (8 * off)) % 256;
                if (o.sgn && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = ((d >> (8 * off)) % 256) + 256 * ((d >> (8 * (off + 1))) % 256);
                if (o.sgn && v >= 32768) v = v - 65536;
            end
            default: v = d;
        endcase
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic present(input op_t o);
        bus.req_valid  = 1'b1;
        bus.req_store  = o.store;
        bus.req_size   = o.size;
        bus.req_signed = o.sgn;
        bus.req_addr   = o.addr;
        bus.req_wdata  = o.wdata;
        bus.req_rd     = o.rd;
    endtask

    // Called #1 after the accept edge; runs the access and checks the RESP cycle.
    task automatic service(input op_t o);
        bit ill = model_illegal(o);
        bit terr;
        int cyc;
        bus.req_valid = 1'b0;
        terr = ill || (o.waits >= TIMEOUT);
        if (!ill) begin
            cyc = (o.waits < TIMEOUT) ? o.waits + 1 : TIMEOUT;
            for (int c = 0; c < cyc; c++) begin
                check("mre_access", bus.MRE, !o.store);
                check("mwe_access", bus.MWE, o.store);
                check("addressData", bus.addressData, o.addr & ~32'h3);
                check("mem_be", bus.mem_be, model_be(o));
                if (o.store) check("storeData", bus.storeData, model_sdata(o));
                bus.req_valid = 1'b1;
                #1;
                check("stall", bus.stall, 1'b1);
                bus.mem_ready  = (c == o.waits);
                bus.loadedData = (c == o.waits) ? o.rdata : $urandom;
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
                bus.req_valid = 1'b0;
            end
        end
        check("mre_resp", bus.MRE, 1'b0);
        check("mwe_resp", bus.MWE, 1'b0);
        check("ready_resp", bus.req_ready, 1'b1);
        check("err", bus.err, terr);
        check("wb_valid", bus.wb_valid, !terr && !o.store);
        check("st_done", bus.st_done, !terr && o.store);
        if (!terr && !o.store) begin
            check("wb_data", bus.wb_data, model_load(o));
            check("wb_rd", bus.wb_rd, o.rd);
        end
    endtask

    task automatic run_op(input op_t o);
        present(o);
        @(posedge clk);
        #1;
        service(o);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_wb_valid", bus.wb_valid, 1'b0);
            check("idle_err", bus.err, 1'b0);
            check("idle_st_done", bus.st_done, 1'b0);
            check("idle_mre", bus.MRE, 1'b0);
            check("idle_ready", bus.req_ready, 1'b1);
        end
    endtask

    function automatic op_t mk(bit st, logic [1:0] sz, bit sg, logic [31:0] a,
                               logic [31:0] w, logic [31:0] r, logic [3:0] rd, int wt);
        op_t o;
        o.store = st; o.size = sz; o.sgn = sg; o.addr = a;
        o.wdata = w;  o.rdata = r; o.rd = rd;  o.waits = wt;
        return o;
    endfunction

    // Directed steps followed by randomized ops
    initial begin
        op_t o;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req_valid = 0; bus.req_store = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0;
        bus.mem_ready = 0; bus.loadedData = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_mre", bus.MRE, 1'b0);
        check("rst_mwe", bus.MWE, 1'b0);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_ready", bus.req_ready, 1'b1);
        rst = 1'b0;
        idle(1);

        // Word load, two wait states
        run_op(mk(0, 2'd2, 0, 32'h10, 0, 32'hDEADBEEF, 4'd5, 2));
        check("t1_wb_data_const", bus.wb_data, 32'hDEADBEEF);
        idle(1);
        // Signed / unsigned byte loads from the top lane
        run_op(mk(0, 2'd0, 1, 32'h13, 0, 32'h80FF_0000, 4'd3, 0));
        check("t2_signed_const", bus.wb_data, 32'hFFFFFF80);
        idle(1);
        run_op(mk(0, 2'd0, 0, 32'h13, 0, 32'h80FF_0000, 4'd3, 0));
        check("t2_unsigned_const", bus.wb_data, 32'h00000080);
        idle(1);
        // Half store at 0x22
        run_op(mk(1, 2'd1, 0, 32'h22, 32'h1234ABCD, 0, 4'd0, 1));
        idle(1);
        // Misaligned word, then reserved size
        run_op(mk(0, 2'd2, 0, 32'h21, 0, 0, 4'd1, 0));
        idle(1);
        run_op(mk(0, 2'd3, 0, 32'h20, 0, 0, 4'd1, 0));
        idle(1);
        // Timeout, then completion on the last allowed cycle
        run_op(mk(0, 2'd2, 0, 32'h40, 0, 32'h1111_2222, 4'd7, 100));
        idle(1);
        check("t5_state_idle", dbg_state, IDLE);
        run_op(mk(0, 2'd2, 0, 32'h44, 0, 32'h3333_4444, 4'd8, TIMEOUT - 1));
        idle(1);

        // Reset in the middle of an access wait
        o = mk(0, 2'd2, 0, 32'h80, 0, 0, 4'd2, 100);
        present(o);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("t6_mre_before_rst", bus.MRE, 1'b1);
        repeat (3) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_mre", bus.MRE, 1'b0);
        check("t6_addr", bus.addressData, 32'h0);
        check("t6_be", bus.mem_be, 4'h0);
        check("t6_wb_valid", bus.wb_valid, 1'b0);
        check("t6_err", bus.err, 1'b0);
        check("t6_wb_data", bus.wb_data, 32'h0);
        check("t6_state", dbg_state, IDLE);
        // mem_ready outside ACCESS is ignored
        bus.mem_ready = 1'b1;
        bus.loadedData = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        check("t6_ignored_ready", bus.wb_valid, 1'b0);
        idle(1);

        // Back-to-back: each op is presented during the previous RESP cycle
        run_op(mk(0, 2'd2, 0, 32'h100, 0, 32'hCAFE_F00D, 4'd9, 0));
        run_op(mk(0, 2'd1, 1, 32'h102, 0, 32'h8001_0000, 4'd10, 0));
        run_op(mk(1, 2'd0, 0, 32'h105, 32'h0000_005A, 0, 4'd0, 0));
        idle(1);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            o.store = 1'($urandom_range(0, 1));
            o.size  = 2'($urandom_range(0, 3));
            o.sgn   = 1'($urandom_range(0, 1));
            o.addr  = 32'($urandom_range(0, 255));
            o.wdata = $urandom;
            o.rdata = $urandom;
            o.rd    = 4'($urandom_range(0, 15));
            o.waits = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            run_op(o);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
